life_display_ctrl: RTL and testbench
====================================

LIFE_DISPLAY_CTRL -- requirements
Module: life_display_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- SPR_X0, 520, sprite left column.
- SPR_Y0, 10, sprite top row.
- SPR_W, 100, sprite width in pixels.
- SPR_H, 30, sprite height in pixels (SPR_W*SPR_H <= 3000).
- BLINK_FRAMES, 8, frames per visibility toggle.
- BLINK_TOGGLES, 6, toggles per blink sequence.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- Clk  in  1  sole clock.
- Reset  in  1  synchronous, active-high.
- vsync_pulse  in  1  one-cycle frame-start strobe.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- life_dec  in  1  one-cycle lose-a-life strobe.
- life_restore  in  1  one-cycle set-lives-to-3 strobe.
- rom_data  in  4  palette index returned by sprite ROM (combinational read).
- read_address  out  19  sprite ROM address.
- life  out  3  sprite select to ROM (1..3; 0 = none).
- pixel_on  out  1  draw sprite pixel this cycle.
- pixel_idx  out  4  palette index to draw.
- game_over  out  1  lives exhausted.

Function
REQ-003 Internal count lives SHALL range 0..3, 2-bit saturating, and never wrap.
REQ-004 life_dec with lives>0 SHALL decrement lives on the next edge; life_dec at lives==0 SHALL be ignored.
REQ-005 life_restore SHALL set lives=3, cancel any blink and enter IDLE; simultaneous life_restore and life_dec SHALL act as restore only.
REQ-006 Output life SHALL update only on cycles with vsync_pulse=1, loading the current lives value, so the sprite never changes mid-frame.
REQ-007 The FSM SHALL have states IDLE, BLINK and DEAD; reset state SHALL be IDLE.
REQ-008 IDLE->BLINK SHALL occur on accepted life_dec; toggle counter and frame counter SHALL clear, and visible SHALL go 0.
REQ-009 In BLINK, the frame counter SHALL count vsync_pulse; at BLINK_FRAMES it SHALL clear, invert visible and increment the toggle counter.
REQ-010 When the toggle counter reaches BLINK_TOGGLES, the FSM SHALL set visible=1 and go to IDLE if lives>0, else DEAD.
REQ-011 An accepted life_dec during BLINK SHALL decrement lives and restart the sequence per REQ-008.
REQ-012 DEAD SHALL hold visible=0 and exit only via life_restore or Reset.
REQ-013 game_over SHALL be registered, equal (state==DEAD), and lag the state by 0 cycles, being decoded from the state register.
REQ-014 Stage 1 (cycle n+1) SHALL register in_win = (SPR_X0<=DrawX<SPR_X0+SPR_W) && (SPR_Y0<=DrawY<SPR_Y0+SPR_H).
REQ-015 Stage 1 SHALL register read_address = (DrawY-SPR_Y0)*SPR_W + (DrawX-SPR_X0), zero-extended to 19 bits, or 0 when outside the window.
REQ-016 Stage 2 (cycle n+2) SHALL register pixel_idx=rom_data and pixel_on = in_win_d & visible & (life!=0) & (rom_data!=0); index 0 is transparent.
REQ-017 When pixel_on=0, pixel_idx SHALL be 0; total DrawX/DrawY-to-pixel_on latency SHALL be exactly 2 cycles.
REQ-018 Pipeline registers SHALL advance every cycle with no stall.

Reset
REQ-019 On Reset=1 at an edge, all of the following SHALL hold next cycle: lives=3, life=3, state=IDLE, visible=1, counters=0, read_address=0, pixel_on=0, pixel_idx=0, game_over=0.
REQ-020 Reset SHALL override vsync_pulse, life_dec and life_restore in the same cycle, including mid-BLINK.

Verification
REQ-021 Reset, then drive DrawX=530, DrawY=12 -> read_address=210 at n+1; rom_data=5 -> pixel_on=1, pixel_idx=5 at n+2.
REQ-022 Drive DrawX=519 or DrawX=620 (edge of window) -> read_address=0 and pixel_on=0; DrawX=619, DrawY=39 -> read_address=2999.
REQ-023 Pulse life_dec mid-frame -> life stays 3 until next vsync_pulse, then 2; visible alternates every 8 frames for 48 frames, then IDLE with visible=1.
REQ-024 Apply three life_dec pulses, a fourth life_dec and 48 frames -> lives=0 (no wrap), life=0, DEAD, game_over=1, pixel_on=0; then life_restore -> lives=3, IDLE, game_over=0.
REQ-025 Pulse life_dec and life_restore in the same cycle -> lives=3 and no BLINK; assert Reset mid-BLINK -> all REQ-019 values next cycle.
REQ-026 Drive rom_data=0 inside the window -> pixel_on=0 and pixel_idx=0.

Source files
------------

// File: rtl/life_display_ctrl.sv
// Lives counter, blink FSM and two-stage sprite pixel pipeline for a life indicator.
// Latency: DrawX/DrawY -> read_address 1 cycle, -> pixel_on/pixel_idx 2 cycles.
// Backpressure: none; the pipeline advances every cycle and never stalls.
module life_display_ctrl #(
  parameter int SPR_X0        = 520,
  parameter int SPR_Y0        = 10,
  parameter int SPR_W         = 100,
  parameter int SPR_H         = 30,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync_pulse,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        life_dec,
  input  logic        life_restore,
  input  logic [3:0]  rom_data,
  output logic [18:0] read_address,
  output logic [2:0]  life,
  output logic        pixel_on,
  output logic [3:0]  pixel_idx,
  output logic        game_over
);

  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam int TCW = $clog2(BLINK_TOGGLES + 1);

  // Window bounds widened by one bit so X0+W cannot overflow the compare.
  localparam logic [10:0] X_LO = 11'(SPR_X0);
  localparam logic [10:0] X_HI = 11'(SPR_X0 + SPR_W);
  localparam logic [10:0] Y_LO = 11'(SPR_Y0);
  localparam logic [10:0] Y_HI = 11'(SPR_Y0 + SPR_H);
  localparam logic [9:0]  X0_10 = 10'(SPR_X0);
  localparam logic [9:0]  Y0_10 = 10'(SPR_Y0);

  typedef enum logic [1:0] {IDLE, BLINK, DEAD} state_t;

  state_t           state, state_n;
  logic [1:0]       lives, lives_n;
  logic [FCW-1:0]   frame_cnt, frame_n;
  logic [TCW-1:0]   toggle_cnt, toggle_n, toggle_inc;
  logic             visible, visible_n;
  logic             accept_dec;

  logic [10:0]      x_ext, y_ext;
  logic [9:0]       dx, dy;
  logic             in_win_c, in_win_d;
  logic [18:0]      addr_c;
  logic             draw_c;

  // Restore wins over a simultaneous decrement; decrement at zero lives is dropped.
  assign accept_dec = life_dec && (lives != 2'd0) && !life_restore;
  assign toggle_inc = toggle_cnt + 1'b1;

  // Next-state logic for lives, blink counters and visibility.
  always_comb begin
    state_n   = state;
    lives_n   = lives;
    frame_n   = frame_cnt;
    toggle_n  = toggle_cnt;
    visible_n = visible;
    if (life_restore) begin
      state_n   = IDLE;
      lives_n   = 2'd3;
      frame_n   = '0;
      toggle_n  = '0;
      visible_n = 1'b1;
    end else if (accept_dec) begin
      // A hit during an ongoing blink restarts the sequence from the top.
      state_n   = BLINK;
      lives_n   = lives - 2'd1;
      frame_n   = '0;
      toggle_n  = '0;
      visible_n = 1'b0;
    end else begin
      case (state)
        BLINK: begin
          if (vsync_pulse) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
              frame_n   = '0;
              toggle_n  = toggle_inc;
              visible_n = ~visible;
              if (toggle_inc == TCW'(BLINK_TOGGLES)) begin
                // Sequence done: reappear if lives remain, otherwise stay dark.
                toggle_n  = '0;
                state_n   = (lives != 2'd0) ? IDLE : DEAD;
                visible_n = (lives != 2'd0);
              end
            end else begin
              frame_n = frame_cnt + 1'b1;
            end
          end
        end
        DEAD:    visible_n = 1'b0;
        default: ;
      endcase
    end
  end

  // State register for the FSM and its counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      lives      <= 2'd3;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
      visible    <= 1'b1;
    end else begin
      state      <= state_n;
      lives      <= lives_n;
      frame_cnt  <= frame_n;
      toggle_cnt <= toggle_n;
      visible    <= visible_n;
    end
  end

  assign game_over = (state == DEAD);

  // Sprite select only changes at frame start so a frame never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      life <= 3'd3;
    end else if (vsync_pulse) begin
      life <= {1'b0, lives};
    end
  end

  assign x_ext    = {1'b0, DrawX};
  assign y_ext    = {1'b0, DrawY};
  assign in_win_c = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign dx       = DrawX - X0_10;
  assign dy       = DrawY - Y0_10;
  assign addr_c   = 19'(dy) * 19'(SPR_W) + 19'(dx);

  // Stage 1: window hit and ROM address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_win_d     <= 1'b0;
      read_address <= '0;
    end else begin
      in_win_d     <= in_win_c;
      read_address <= in_win_c ? addr_c : 19'd0;
    end
  end

  // Palette index 0 is transparent.
  assign draw_c = in_win_d && visible && (life != 3'd0) && (rom_data != 4'd0);

  // Stage 2: final pixel decision on the ROM data returned for stage 1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on  <= 1'b0;
      pixel_idx <= 4'd0;
    end else begin
      pixel_on  <= draw_c;
      pixel_idx <= draw_c ? rom_data : 4'd0;
    end
  end

endmodule

// File: tb/tb_life_display_ctrl.sv
// Scoreboard bench for life_display_ctrl: stimulus queues expected outputs
// tagged with the cycle they must appear in; a negedge monitor pops them.
module tb_life_display_ctrl;

  localparam int K_ADDR = 0;
  localparam int K_ON   = 1;
  localparam int K_IDX  = 2;
  localparam int K_LIFE = 3;
  localparam int K_GO   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        vsync_pulse;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        life_dec;
  logic        life_restore;
  logic [3:0]  rom_data;
  logic [18:0] read_address;
  logic [2:0]  life;
  logic        pixel_on;
  logic [3:0]  pixel_idx;
  logic        game_over;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  life_display_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vsync_pulse  (vsync_pulse),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .life_dec     (life_dec),
    .life_restore (life_restore),
    .rom_data     (rom_data),
    .read_address (read_address),
    .life         (life),
    .pixel_on     (pixel_on),
    .pixel_idx    (pixel_idx),
    .game_over    (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Expect output 'kind' to equal 'val' dc cycles from now.
  function automatic void want(input int dc, input int kind, input int val);
    exp_t e;
    e.cyc  = cyc + dc;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endfunction

  function automatic int dut_val(input int kind);
    case (kind)
      K_ADDR:  return int'(read_address);
      K_ON:    return int'(pixel_on);
      K_IDX:   return int'(pixel_idx);
      K_LIFE:  return int'(life);
      default: return int'(game_over);
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_ADDR:  return "read_address";
      K_ON:    return "pixel_on";
      K_IDX:   return "pixel_idx";
      K_LIFE:  return "life";
      default: return "game_over";
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge Clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        int act;
        act = dut_val(q[i].kind);
        vectors++;
        if (act != q[i].val) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", kname(q[i].kind), cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  // Present one pixel coordinate and the ROM data that will answer it a cycle later.
  task automatic pix(input int x, input int y, input int rd,
                     input int ea, input int eon, input int eidx);
    DrawX = 10'(x);
    DrawY = 10'(y);
    want(1, K_ADDR, ea);
    want(2, K_ON, eon);
    want(2, K_IDX, eidx);
    tick();
    rom_data = 4'(rd);
  endtask

  // One frame: a vsync strobe followed by two quiet cycles.
  task automatic frame();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    tick(2);
  endtask

  task automatic pulse_dec();
    life_dec = 1'b1;
    tick();
    life_dec = 1'b0;
    tick();
  endtask

  initial begin
    Reset        = 1'b1;
    vsync_pulse  = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    life_dec     = 1'b0;
    life_restore = 1'b0;
    rom_data     = '0;
    tick(2);
    want(1, K_LIFE, 3);
    want(1, K_GO, 0);
    want(1, K_ADDR, 0);
    want(1, K_ON, 0);
    want(1, K_IDX, 0);
    tick();
    Reset = 1'b0;

    // Pixel pipeline, back to back.
    pix(530, 12, 5, 210, 1, 5);
    pix(519, 12, 7, 0, 0, 0);
    pix(620, 12, 7, 0, 0, 0);
    pix(619, 39, 3, 2999, 1, 3);
    pix(520, 10, 9, 0, 1, 9);
    pix(530, 12, 0, 210, 0, 0);
    pix(530, 9, 4, 0, 0, 0);
    pix(530, 40, 4, 0, 0, 0);
    tick(3);

    // Park on an opaque sprite pixel so pixel_on tracks visibility.
    DrawX    = 10'd530;
    DrawY    = 10'd12;
    rom_data = 4'd5;
    tick(3);
    want(1, K_ON, 1);
    tick(2);

    // Single hit mid-frame, then a full blink sequence.
    life_dec = 1'b1;
    want(1, K_LIFE, 3);
    want(3, K_ON, 0);
    tick();
    life_dec = 1'b0;
    tick(4);
    want(1, K_LIFE, 3);
    tick(2);
    for (int k = 1; k <= 48; k++) begin
      if (k == 1) want(1, K_LIFE, 2);
      want(3, K_ON, (k == 48) ? 1 : ((k / 8) % 2));
      frame();
    end
    want(1, K_GO, 0);
    tick(2);

    // Restore back to three lives.
    life_restore = 1'b1;
    tick();
    life_restore = 1'b0;
    want(1, K_LIFE, 3);
    frame();

    // Three hits empty the lives; a fourth must not wrap.
    pulse_dec();
    pulse_dec();
    pulse_dec();
    pulse_dec();
    for (int k = 1; k <= 48; k++) begin
      if (k == 1) want(1, K_LIFE, 0);
      if (k == 47) want(3, K_GO, 0);
      if (k == 48) begin
        want(3, K_GO, 1);
        want(3, K_ON, 0);
        want(3, K_LIFE, 0);
      end
      frame();
    end
    // DEAD holds across further frames.
    want(3, K_GO, 1);
    want(3, K_ON, 0);
    frame();

    // Restore out of DEAD.
    life_restore = 1'b1;
    want(1, K_GO, 0);
    want(1, K_LIFE, 0);
    tick();
    life_restore = 1'b0;
    tick();
    want(1, K_LIFE, 3);
    want(3, K_ON, 1);
    frame();

    // Simultaneous hit and restore acts as restore only.
    life_dec     = 1'b1;
    life_restore = 1'b1;
    tick();
    life_dec     = 1'b0;
    life_restore = 1'b0;
    want(3, K_ON, 1);
    tick();
    want(1, K_LIFE, 3);
    want(3, K_ON, 1);
    frame();

    // Reset in the middle of a blink, with competing strobes.
    pulse_dec();
    want(1, K_LIFE, 2);
    want(3, K_ON, 0);
    frame();
    frame();
    frame();
    Reset       = 1'b1;
    vsync_pulse = 1'b1;
    life_dec    = 1'b1;
    want(1, K_LIFE, 3);
    want(1, K_GO, 0);
    want(1, K_ADDR, 0);
    want(1, K_ON, 0);
    want(1, K_IDX, 0);
    want(2, K_ADDR, 210);
    want(3, K_ON, 1);
    want(3, K_IDX, 5);
    tick();
    Reset       = 1'b0;
    vsync_pulse = 1'b0;
    life_dec    = 1'b0;
    tick(5);

    if (q.size() != 0) begin
      $display("FAIL unchecked_expectations left=%0d", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
